// File: rtl/asi_arb.sv
// asi_arb: CH_N-channel burst arbiter that muxes one granted channel onto a RAM port
// and returns read data to the issuer. Define ASI_ARB_QOS_EN for priority-based selection.
module asi_arb #(
  parameter int CH_N   = 4,
  parameter int AW     = 32,
  parameter int DW     = 64,
  parameter int SLV_WS = 2,
  parameter int PRI_W  = 4
) (
  input  logic                    usr_clk,
  input  logic                    usr_reset_n,
  input  logic [CH_N-1:0]         req_v,
  input  logic [CH_N-1:0]         req_we,
  input  logic [CH_N*AW-1:0]      req_addr,
  input  logic [CH_N*DW-1:0]      req_wdata,
  input  logic [CH_N*DW/8-1:0]    req_wstrb,
  input  logic [CH_N-1:0]         req_beat,
  input  logic [CH_N-1:0]         req_last,
`ifdef ASI_ARB_QOS_EN
  input  logic [CH_N*PRI_W-1:0]   req_pri,
`endif
  output logic [CH_N-1:0]         gnt,
  output logic                    m_we,
  output logic                    m_re,
  output logic [AW-1:0]           m_addr,
  output logic [DW-1:0]           m_wdata,
  output logic [DW/8-1:0]         m_wstrb,
  input  logic [DW-1:0]           m_rdata,
  output logic [CH_N-1:0]         rsp_valid,
  output logic                    rsp_last,
  output logic [DW-1:0]           rsp_rdata,
  output logic                    busy
);

  localparam int PTR_W = (CH_N > 1) ? $clog2(CH_N) : 1;

  typedef enum logic {IDLE, GNT} state_t;

  state_t                 state_q;
  logic [CH_N-1:0]        gnt_q;
  logic [PTR_W-1:0]       ptr_q;
  logic [PTR_W-1:0]       gidx;
  logic                   beat_last;

  logic [CH_N*PRI_W-1:0]  pri_sel;
  logic [CH_N-1:0]        cand;
  logic [PTR_W-1:0]       sel_base;
  logic [PTR_W:0]         pos;
  logic [PTR_W-1:0]       idx;
  logic [PRI_W-1:0]       idx_pri;
  logic [PRI_W-1:0]       best_pri;
  logic                   win_found;
  logic [PTR_W-1:0]       win_idx;
  logic [CH_N-1:0]        win_oh;

  logic [CH_N-1:0]        ret_v_d;
  logic                   ret_l_d;
  logic                   dl_busy;

  // Without QoS every channel carries equal priority, which reduces to plain round-robin.
`ifdef ASI_ARB_QOS_EN
  assign pri_sel = req_pri;
`else
  assign pri_sel = '0;
`endif

  always_comb begin
    gidx = '0;
    for (int unsigned i = 0; i < CH_N; i++) begin
      if (gnt_q[i]) gidx = PTR_W'(i);
    end
  end

  // RAM port: OR-mux over the one-hot grant, zero unless the granted channel beats.
  always_comb begin
    m_we      = 1'b0;
    m_re      = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    m_wstrb   = '0;
    beat_last = 1'b0;
    for (int unsigned i = 0; i < CH_N; i++) begin
      if (gnt_q[i] && req_beat[i]) begin
        m_we      = m_we | req_we[i];
        m_re      = m_re | ~req_we[i];
        m_addr    = m_addr | req_addr[i*AW +: AW];
        m_wdata   = m_wdata | req_wdata[i*DW +: DW];
        m_wstrb   = m_wstrb | req_wstrb[i*(DW/8) +: DW/8];
        beat_last = beat_last | req_last[i];
      end
    end
  end

  // At burst end the pointer becomes g, so the scan base is g and g itself is masked out.
  always_comb begin
    cand      = (state_q == GNT) ? (req_v & ~gnt_q) : req_v;
    sel_base  = (state_q == GNT) ? gidx : ptr_q;
    win_found = 1'b0;
    win_idx   = '0;
    best_pri  = '0;
    pos       = '0;
    idx       = '0;
    idx_pri   = '0;
    for (int unsigned k = 1; k <= CH_N; k++) begin
      pos = {1'b0, sel_base} + (PTR_W+1)'(k);
      if (pos >= (PTR_W+1)'(CH_N)) pos = pos - (PTR_W+1)'(CH_N);
      idx     = pos[PTR_W-1:0];
      idx_pri = pri_sel[idx*PRI_W +: PRI_W];
      if (cand[idx] && (!win_found || idx_pri > best_pri)) begin
        win_found = 1'b1;
        win_idx   = idx;
        best_pri  = idx_pri;
      end
    end
    win_oh = win_found ? (CH_N'(1) << win_idx) : '0;
  end

  always_ff @(posedge usr_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= PTR_W'(CH_N - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_v) begin
            gnt_q   <= win_oh;
            state_q <= GNT;
          end
        end
        GNT: begin
          if (beat_last) begin
            ptr_q <= gidx;
            if (win_found) begin
              gnt_q <= win_oh;
            end else begin
              gnt_q   <= '0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          gnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ret_v_d = gnt_q & {CH_N{m_re}};
  assign ret_l_d = m_re & beat_last;

  generate
    if (SLV_WS == 0) begin : g_ret_comb
      assign rsp_valid = ret_v_d;
      assign rsp_last  = ret_l_d;
      assign dl_busy   = 1'b0;
    end else begin : g_ret_dl
      logic [CH_N-1:0] v_q [SLV_WS];
      logic            l_q [SLV_WS];

      always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) begin
          for (int unsigned s = 0; s < SLV_WS; s++) begin
            v_q[s] <= '0;
            l_q[s] <= 1'b0;
          end
        end else begin
          v_q[0] <= ret_v_d;
          l_q[0] <= ret_l_d;
          for (int unsigned s = 1; s < SLV_WS; s++) begin
            v_q[s] <= v_q[s-1];
            l_q[s] <= l_q[s-1];
          end
        end
      end

      always_comb begin
        dl_busy = 1'b0;
        for (int unsigned s = 0; s < SLV_WS; s++) begin
          dl_busy = dl_busy | (|v_q[s]);
        end
      end

      assign rsp_valid = v_q[SLV_WS-1];
      assign rsp_last  = l_q[SLV_WS-1];
    end
  endgenerate

  assign gnt       = gnt_q;
  assign rsp_rdata = m_rdata;
  assign busy      = (state_q == GNT) | dl_busy;

endmodule

// File: tb/tb_asi_arb.sv
// Self-checking bench for asi_arb: directed scenarios plus randomized traffic
// compared against a channel-level arbitration model.
module tb_asi_arb;

  localparam int CH_N   = 4;
  localparam int AW     = 32;
  localparam int DW     = 64;
  localparam int SLV_WS = 2;
  localparam int PRI_W  = 4;

  logic                   usr_clk = 1'b0;
  logic                   usr_reset_n;
  logic [CH_N-1:0]        req_v, req_we, req_beat, req_last;
  logic [CH_N*AW-1:0]     req_addr;
  logic [CH_N*DW-1:0]     req_wdata;
  logic [CH_N*DW/8-1:0]   req_wstrb;
  logic [CH_N*PRI_W-1:0]  req_pri;
  logic [CH_N-1:0]        gnt, rsp_valid;
  logic                   m_we, m_re, rsp_last, busy;
  logic [AW-1:0]          m_addr;
  logic [DW-1:0]          m_wdata, m_rdata, rsp_rdata;
  logic [DW/8-1:0]        m_wstrb;

  int checks = 0;
  int errors = 0;

  always #5 usr_clk = ~usr_clk;

  asi_arb #(.CH_N(CH_N), .AW(AW), .DW(DW), .SLV_WS(SLV_WS), .PRI_W(PRI_W)) dut (
    .usr_clk(usr_clk), .usr_reset_n(usr_reset_n),
    .req_v(req_v), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .req_beat(req_beat), .req_last(req_last),
`ifdef ASI_ARB_QOS_EN
    .req_pri(req_pri),
`endif
    .gnt(gnt), .m_we(m_we), .m_re(m_re), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rdata(m_rdata), .rsp_valid(rsp_valid), .rsp_last(rsp_last),
    .rsp_rdata(rsp_rdata), .busy(busy)
  );

  // Reference model: granted channel (-1 = none), pointer, scheduled read returns.
  typedef struct { int due; int ch; bit last; } rsp_t;
  rsp_t rq[$];
  int   m_cur, m_ptr, cyc;
  logic [CH_N-1:0]  e_gnt, e_rv;
  logic             e_we, e_re, e_rl, e_busy;
  logic [AW-1:0]    e_addr;
  logic [DW-1:0]    e_wd;
  logic [DW/8-1:0]  e_ws;

  bit       ag_pend [CH_N];
  int       ag_rem  [CH_N];
  bit       ag_we   [CH_N];
  logic [AW-1:0] ag_addr [CH_N];

  function automatic int pri_of(input int c);
`ifdef ASI_ARB_QOS_EN
    return int'(req_pri[c*PRI_W +: PRI_W]);
`else
    return 0;
`endif
  endfunction

  function automatic int pick(input logic [CH_N-1:0] cnd, input int base);
    int best = -1;
    for (int k = 1; k <= CH_N; k++) begin
      automatic int c = (base + k) % CH_N;
      if (cnd[c] && (best < 0 || pri_of(c) > pri_of(best))) best = c;
    end
    return best;
  endfunction

  task automatic model_reset();
    m_cur = -1; m_ptr = CH_N - 1; cyc = 0; rq.delete();
  endtask

  task automatic model_eval();
    e_gnt = '0; e_we = 0; e_re = 0; e_addr = '0; e_wd = '0; e_ws = '0;
    e_rv = '0; e_rl = 0; e_busy = (m_cur >= 0);
    if (m_cur >= 0) begin
      e_gnt[m_cur] = 1'b1;
      if (req_beat[m_cur]) begin
        e_we   = req_we[m_cur];
        e_re   = !req_we[m_cur];
        e_addr = req_addr[m_cur*AW +: AW];
        e_wd   = req_wdata[m_cur*DW +: DW];
        e_ws   = req_wstrb[m_cur*(DW/8) +: DW/8];
      end
    end
    foreach (rq[j]) begin
      if (rq[j].due == cyc) begin e_rv[rq[j].ch] = 1'b1; e_rl = rq[j].last; end
      if (rq[j].due >= cyc) e_busy = 1'b1;
    end
  endtask

  task automatic model_clock();
    logic [CH_N-1:0] cnd;
    if (m_cur >= 0 && req_beat[m_cur] && !req_we[m_cur])
      rq.push_back('{cyc + SLV_WS, m_cur, req_last[m_cur]});
    if (m_cur < 0) begin
      m_cur = pick(req_v, m_ptr);
    end else if (req_beat[m_cur] && req_last[m_cur]) begin
      m_ptr = m_cur;
      cnd = req_v; cnd[m_cur] = 1'b0;
      m_cur = pick(cnd, m_ptr);
    end
    cyc++;
    while (rq.size() > 0 && rq[0].due < cyc) void'(rq.pop_front());
  endtask

  task automatic clear_inputs();
    req_v = '0; req_we = '0; req_beat = '0; req_last = '0;
    req_addr = '0; req_wdata = '0; req_wstrb = '0; req_pri = '0; m_rdata = '0;
  endtask

  task automatic do_reset();
    usr_reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge usr_clk);
    #1 usr_reset_n = 1'b1;
    model_reset();
  endtask

  task automatic next_cycle();
    @(posedge usr_clk);
    #1;
  endtask

  task automatic test_reset();
    usr_reset_n = 1'b0;
    clear_inputs();
    req_v = '1; req_beat = '1; req_addr = '1;
    #1;
    checks++;
    if ({gnt, m_we, m_re, rsp_valid, rsp_last, busy} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got gnt=%b we=%b re=%b rv=%b rl=%b busy=%b expected all 0",
               gnt, m_we, m_re, rsp_valid, rsp_last, busy);
    end
    checks++;
    if ({m_addr, m_wdata, m_wstrb} !== '0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h wdata=%h wstrb=%h expected 0", m_addr, m_wdata, m_wstrb);
    end
    do_reset();
  endtask

  task automatic test_rr_all();
    logic [CH_N-1:0] eg;
    do_reset();
    req_v = '1; req_beat = '1; req_we = '1;
    for (int i = 0; i < CH_N; i++) req_addr[i*AW +: AW] = 32'h1000 * (i + 1);
    for (int t = 0; t < 13; t++) begin
      req_last = (t > 0 && t % 2 == 0) ? '1 : '0;
      @(negedge usr_clk);
      eg = (t == 0) ? '0 : CH_N'(1 << (((t - 1) / 2) % CH_N));
      checks++;
      if (gnt !== eg) begin
        errors++;
        $display("FAIL rr_gnt t=%0d: got %b expected %b", t, gnt, eg);
      end
      if (t > 0) begin
        checks++;
        if (m_we !== 1'b1 || m_addr !== 32'h1000 * (((t - 1) / 2) % CH_N + 1)) begin
          errors++;
          $display("FAIL rr_beat t=%0d: got we=%b addr=%h expected we=1 addr=%h",
                   t, m_we, m_addr, 32'h1000 * (((t - 1) / 2) % CH_N + 1));
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_read_ch2();
    logic [CH_N-1:0] erv;
    logic [AW-1:0]   ea;
    logic            ere;
    do_reset();
    req_addr = {CH_N*AW/32{32'hdead_beef}};
    for (int t = 0; t < 8; t++) begin
      req_v[2]    = (t <= 3);
      req_beat[2] = (t >= 1 && t <= 3);
      req_last[2] = (t == 3);
      req_addr[2*AW +: AW] = 32'h100 + 32'(8 * (t - 1));
      m_rdata = {$urandom, $urandom};
      @(negedge usr_clk);
      ere = (t >= 1 && t <= 3);
      ea  = ere ? 32'h100 + 32'(8 * (t - 1)) : '0;
      erv = (t >= 3 && t <= 5) ? 4'b0100 : 4'b0000;
      checks++;
      if (m_re !== ere || m_we !== 1'b0 || m_addr !== ea) begin
        errors++;
        $display("FAIL rd_issue t=%0d: got re=%b we=%b addr=%h expected re=%b we=0 addr=%h",
                 t, m_re, m_we, m_addr, ere, ea);
      end
      checks++;
      if (rsp_valid !== erv || rsp_last !== (t == 5) || rsp_rdata !== m_rdata) begin
        errors++;
        $display("FAIL rd_return t=%0d: got rv=%b rl=%b data=%h expected rv=%b rl=%b data=%h",
                 t, rsp_valid, rsp_last, rsp_rdata, erv, (t == 5), m_rdata);
      end
      checks++;
      if (busy !== (t >= 1 && t <= 5)) begin
        errors++;
        $display("FAIL rd_busy t=%0d: got %b expected %b", t, busy, (t >= 1 && t <= 5));
      end
      next_cycle();
    end
  endtask

  task automatic test_handover();
    logic [CH_N-1:0] eg;
    do_reset();
    req_we = 4'b0010;
    req_wdata[1*DW +: DW] = 64'h1111_2222_3333_4444;
    req_wstrb[1*8 +: 8]   = 8'h5a;
    req_addr[3*AW +: AW]  = 32'h300;
    for (int t = 0; t < 7; t++) begin
      req_v[1]    = (t <= 2);
      req_beat[1] = (t >= 1 && t <= 3);
      req_last[1] = (t == 2);
      req_addr[1*AW +: AW] = 32'h40 + 32'(8 * (t - 1));
      req_v[3]    = (t <= 4);
      req_beat[3] = (t == 4);
      req_last[3] = (t == 4);
      @(negedge usr_clk);
      eg = (t == 1 || t == 2) ? 4'b0010 : (t == 3 || t == 4) ? 4'b1000 : 4'b0000;
      checks++;
      if (gnt !== eg) begin
        errors++;
        $display("FAIL ho_gnt t=%0d: got %b expected %b", t, gnt, eg);
      end
      if (t == 1 || t == 2) begin
        checks++;
        if (m_we !== 1'b1 || m_addr !== 32'h40 + 32'(8 * (t - 1)) ||
            m_wdata !== 64'h1111_2222_3333_4444 || m_wstrb !== 8'h5a) begin
          errors++;
          $display("FAIL ho_write t=%0d: got we=%b addr=%h wd=%h ws=%h", t, m_we, m_addr, m_wdata, m_wstrb);
        end
      end
      if (t == 3) begin
        checks++;
        if (m_we !== 1'b0 || m_re !== 1'b0 || m_addr !== '0) begin
          errors++;
          $display("FAIL ho_ignored t=3: got we=%b re=%b addr=%h expected 0 0 0", m_we, m_re, m_addr);
        end
      end
      if (t == 4) begin
        checks++;
        if (m_re !== 1'b1 || m_we !== 1'b0 || m_addr !== 32'h300) begin
          errors++;
          $display("FAIL ho_read t=4: got re=%b we=%b addr=%h expected 1 0 300", m_re, m_we, m_addr);
        end
      end
      if (t == 6) begin
        checks++;
        if (rsp_valid !== 4'b1000 || rsp_last !== 1'b1) begin
          errors++;
          $display("FAIL ho_rsp t=6: got rv=%b rl=%b expected 1000 1", rsp_valid, rsp_last);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] eg = 7'b0110110;  // bit t: channel 0 granted in cycle t
    do_reset();
    req_v = 4'b0001; req_beat = 4'b0001; req_we = 4'b0001;
    for (int t = 0; t < 7; t++) begin
      req_last[0] = (t == 2 || t == 5);
      @(negedge usr_clk);
      checks++;
      if (gnt !== {3'b000, eg[t]} || m_we !== eg[t]) begin
        errors++;
        $display("FAIL b2b t=%0d: got gnt=%b we=%b expected gnt=%b we=%b", t, gnt, m_we, {3'b000, eg[t]}, eg[t]);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_v = 4'b0100; req_beat = 4'b0100; req_addr[2*AW +: AW] = 32'h80;
    next_cycle();
    @(negedge usr_clk);
    checks++;
    if (m_re !== 1'b1 || gnt !== 4'b0100) begin
      errors++;
      $display("FAIL rstmid_pre: got re=%b gnt=%b expected 1 0100", m_re, gnt);
    end
    next_cycle();
    #2 usr_reset_n = 1'b0;
    #1;
    checks++;
    if ({gnt, m_we, m_re, m_addr, rsp_valid, rsp_last, busy} !== '0) begin
      errors++;
      $display("FAIL rstmid_now: got gnt=%b we=%b re=%b addr=%h rv=%b rl=%b busy=%b expected all 0",
               gnt, m_we, m_re, m_addr, rsp_valid, rsp_last, busy);
    end
    clear_inputs();
    next_cycle();
    usr_reset_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge usr_clk);
      checks++;
      if (rsp_valid !== '0 || rsp_last !== 1'b0 || busy !== 1'b0 || gnt !== '0) begin
        errors++;
        $display("FAIL rstmid_drop t=%0d: got rv=%b rl=%b busy=%b gnt=%b expected 0", t, rsp_valid, rsp_last, busy, gnt);
      end
      next_cycle();
    end
    req_v = '1;
    next_cycle();
    @(negedge usr_clk);
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL rstmid_first: got %b expected 0001", gnt);
    end
    next_cycle();
  endtask

`ifdef ASI_ARB_QOS_EN
  task automatic test_qos();
    do_reset();
    req_pri = {4'd2, 4'd7, 4'd7, 4'd1};
    req_v = 4'b0010; req_beat = 4'b0010; req_last = 4'b0010;
    next_cycle();
    next_cycle();
    req_v = '1; req_beat = '0; req_last = '0;
    next_cycle();
    req_beat = 4'b0100; req_last = 4'b0100;
    @(negedge usr_clk);
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL qos_first: got %b expected 0100", gnt);
    end
    next_cycle();
    req_beat = '0; req_last = '0;
    @(negedge usr_clk);
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL qos_second: got %b expected 0010", gnt);
    end
    next_cycle();
  endtask
`endif

  task automatic drive_random();
    for (int i = 0; i < CH_N; i++) begin
      if (!ag_pend[i] && $urandom_range(0, 2) == 0) begin
        ag_pend[i] = 1; ag_rem[i] = $urandom_range(1, 4);
        ag_we[i] = 1'($urandom_range(0, 1)); ag_addr[i] = $urandom & ~32'h7;
      end
      req_v[i]    = ag_pend[i];
      req_we[i]   = ag_pend[i] ? ag_we[i] : 1'($urandom_range(0, 1));
      req_beat[i] = ag_pend[i] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      req_last[i] = ag_pend[i] ? (ag_rem[i] == 1) : 1'($urandom_range(0, 1));
      req_addr[i*AW +: AW]         = ag_pend[i] ? ag_addr[i] : $urandom;
      req_wdata[i*DW +: DW]        = {$urandom, $urandom};
      req_wstrb[i*(DW/8) +: DW/8]  = 8'($urandom);
      req_pri[i*PRI_W +: PRI_W]    = 4'($urandom_range(0, 3));
    end
    m_rdata = {$urandom, $urandom};
  endtask

  task automatic agent_update();
    if (m_cur >= 0 && req_beat[m_cur]) begin
      ag_rem[m_cur]--;
      ag_addr[m_cur] += 8;
      if (ag_rem[m_cur] == 0) ag_pend[m_cur] = 0;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < CH_N; i++) begin ag_pend[i] = 0; ag_rem[i] = 0; end
    for (int n = 0; n < 800; n++) begin
      drive_random();
      @(negedge usr_clk);
      model_eval();
      checks++;
      if (gnt !== e_gnt) begin
        errors++;
        $display("FAIL rnd_gnt cyc=%0d: got %b expected %b", cyc, gnt, e_gnt);
      end
      checks++;
      if ({m_we, m_re, m_addr, m_wdata, m_wstrb} !== {e_we, e_re, e_addr, e_wd, e_ws}) begin
        errors++;
        $display("FAIL rnd_mport cyc=%0d: got we=%b re=%b a=%h d=%h s=%h expected we=%b re=%b a=%h d=%h s=%h",
                 cyc, m_we, m_re, m_addr, m_wdata, m_wstrb, e_we, e_re, e_addr, e_wd, e_ws);
      end
      checks++;
      if ({rsp_valid, rsp_last} !== {e_rv, e_rl} || rsp_rdata !== m_rdata) begin
        errors++;
        $display("FAIL rnd_rsp cyc=%0d: got rv=%b rl=%b d=%h expected rv=%b rl=%b d=%h",
                 cyc, rsp_valid, rsp_last, rsp_rdata, e_rv, e_rl, m_rdata);
      end
      checks++;
      if (busy !== e_busy) begin
        errors++;
        $display("FAIL rnd_busy cyc=%0d: got %b expected %b", cyc, busy, e_busy);
      end
      @(posedge usr_clk);
      agent_update();
      model_clock();
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    model_reset();
    test_reset();
    test_rr_all();
    test_read_ch2();
    test_handover();
    test_back_to_back();
    test_reset_mid();
`ifdef ASI_ARB_QOS_EN
    test_qos();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
